// File: rtl/lsu_align_if.sv
//------------------------------------------------------------------------------
// Module : lsu_align_if
// Purpose: Bundles the signals of the load/store alignment unit: the request
//          handshake from the EX/MEM register, the word-wide data memory port,
//          and the registered load response / error pulse.
// Ports  : slave  - view of the alignment unit (consumes requests, drives memory)
//          master - view of the pipeline/memory environment around the unit
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface lsu_align_if #(
  parameter int MEM_AW = 11
);
  // request side
  logic              req_valid_i;
  logic              req_we_i;
  logic [2:0]        req_funct3_i;
  logic [31:0]       req_addr_i;
  logic [31:0]       req_wdata_i;
  logic              req_ready_o;
  // memory side
  logic [MEM_AW-1:0] mem_addr_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;
  // response side
  logic              rsp_valid_o;
  logic [31:0]       rsp_data_o;
  logic              err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
    output req_ready_o,
    output mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  mem_rdata_i,
    output rsp_valid_o, rsp_data_o, err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
    input  req_ready_o,
    input  mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output mem_rdata_i,
    input  rsp_valid_o, rsp_data_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/lsu_align.sv
//------------------------------------------------------------------------------
// Module : lsu_align
// Purpose: MEM-stage load/store alignment unit in front of a word-wide data
//          memory. Turns byte-addressed RV32I loads/stores into word accesses
//          with byte enables, splits word-crossing accesses into two cycles
//          (stalling the pipeline once), and sign/zero-extends load data into
//          a registered response for the MEM/WB boundary.
// Params : MEM_AW      - word-address width toward memory (2**MEM_AW words)
//          MISALIGN_EN - 1: split word-crossing accesses, 0: reject with err
// Ports  : clk_i  - clock
//          rstn_i - asynchronous active-low reset
//          bus    - lsu_align_if.slave: request handshake, memory port,
//                   load response and error pulse
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_align #(
  parameter int MEM_AW      = 11,
  parameter int MISALIGN_EN = 1
) (
  input  wire          clk_i,
  input  wire          rstn_i,
  lsu_align_if.slave   bus
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_SECOND = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       rdata_lo_q, rdata_lo_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              err_q, err_d;

  logic [1:0]        off;
  logic [2:0]        size_b;
  logic [3:0]        size_mask;
  logic              f3_legal;
  logic              split;
  logic              split_allowed;
  logic              reject;
  logic [MEM_AW-1:0] wa;
  logic [7:0]        be_ext;
  logic [63:0]       wdata_ext;
  logic [63:0]       rd_pair;
  logic [31:0]       load_word;

  logic              ready_c;
  logic [MEM_AW-1:0] addr_c;
  logic              we_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c;

  // Address bits above the memory window are intentionally ignored.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr_i[31:MEM_AW+2];

  if (MISALIGN_EN != 0) begin : g_split_en
    assign split_allowed = 1'b1;
  end else begin : g_split_dis
    assign split_allowed = 1'b0;
  end

  assign off = bus.req_addr_i[1:0];
  assign wa  = bus.req_addr_i[MEM_AW+1:2];

  always_comb begin
    size_b    = 3'd4;
    size_mask = 4'b1111;
    case (bus.req_funct3_i[1:0])
      2'b00: begin size_b = 3'd1; size_mask = 4'b0001; end
      2'b01: begin size_b = 3'd2; size_mask = 4'b0011; end
      default: ;
    endcase
    f3_legal = 1'b0;
    case (bus.req_funct3_i)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !bus.req_we_i;
      default:                f3_legal = 1'b0;
    endcase
  end

  assign split  = ({1'b0, off} + size_b) > 3'd4;
  assign reject = !f3_legal || (split && !split_allowed);

  // Both halves of the 8-lane view: low nibble/word is the first access,
  // high nibble/word is what spills into the next word.
  assign be_ext    = {4'b0000, size_mask} << off;
  assign wdata_ext = {32'd0, bus.req_wdata_i} << {off, 3'b000};

  // In SECOND the latched first word sits below the freshly read one, so the
  // same right shift by the byte offset lines up the loaded bytes at bit 0.
  assign rd_pair   = (state_q == S_SECOND) ? {bus.mem_rdata_i, rdata_lo_q}
                                           : {32'd0, bus.mem_rdata_i};
  assign load_word = 32'(rd_pair >> {off, 3'b000});

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  extend = {{24{w[7]}}, w[7:0]};
      3'b001:  extend = {{16{w[15]}}, w[15:0]};
      3'b100:  extend = {24'd0, w[7:0]};
      3'b101:  extend = {16'd0, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    rdata_lo_d  = rdata_lo_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    err_d       = 1'b0;
    ready_c     = 1'b0;
    addr_c      = wa;
    we_c        = 1'b0;
    be_c        = 4'b0000;
    wdata_c     = wdata_ext[31:0];

    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (bus.req_valid_i) begin
          if (reject) begin
            // Consumed in one cycle with no memory side effect.
            err_d = 1'b1;
            if (!bus.req_we_i) begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = 32'd0;
            end
          end else if (split) begin
            ready_c    = 1'b0;
            we_c       = bus.req_we_i;
            be_c       = be_ext[3:0];
            rdata_lo_d = bus.mem_rdata_i;
            state_d    = S_SECOND;
          end else begin
            we_c = bus.req_we_i;
            be_c = be_ext[3:0];
            if (!bus.req_we_i) begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = extend(bus.req_funct3_i, load_word);
            end
          end
        end
      end
      S_SECOND: begin
        // A request vanishing mid-split is abandoned without a second access.
        if (bus.req_valid_i) begin
          ready_c = 1'b1;
          addr_c  = wa + MEM_AW'(1);
          we_c    = bus.req_we_i;
          be_c    = be_ext[7:4];
          wdata_c = wdata_ext[63:32];
          if (!bus.req_we_i) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = extend(bus.req_funct3_i, load_word);
          end
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // No write strobes may escape while reset is asserted.
    if (!rstn_i) begin
      we_c = 1'b0;
      be_c = 4'b0000;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      rdata_lo_q  <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdata_lo_q  <= rdata_lo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready_o = ready_c;
  assign bus.mem_addr_o  = addr_c;
  assign bus.mem_we_o    = we_c;
  assign bus.mem_be_o    = be_c;
  assign bus.mem_wdata_o = wdata_c;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_align.sv
//------------------------------------------------------------------------------
// Module : tb_lsu_align
// Purpose: Self-checking bench for lsu_align. A byte-addressed reference
//          memory predicts load results, stall length, error pulses and
//          response pulses; a second instance covers MISALIGN_EN=0.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lsu_align;

  localparam int MEM_AW  = 11;
  localparam int N_WORDS = 1 << MEM_AW;
  localparam int N_BYTES = N_WORDS * 4;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  lsu_align_if #(.MEM_AW(MEM_AW)) bus ();
  lsu_align_if #(.MEM_AW(MEM_AW)) bus_nm ();

  lsu_align #(.MEM_AW(MEM_AW), .MISALIGN_EN(1)) u_dut (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .bus   (bus)
  );

  lsu_align #(.MEM_AW(MEM_AW), .MISALIGN_EN(0)) u_dut_nm (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .bus   (bus_nm)
  );

  // Word memory attached to the main instance.
  logic [31:0] mem [N_WORDS];
  assign bus.mem_rdata_i = mem[bus.mem_addr_o];
  always @(posedge clk_i) begin
    if (bus.mem_we_o)
      for (int l = 0; l < 4; l++)
        if (bus.mem_be_o[l]) mem[bus.mem_addr_o][8*l +: 8] <= bus.mem_wdata_o[8*l +: 8];
  end

  assign bus_nm.mem_rdata_i = 32'h1234_5678;

  // Independent byte-level reference.
  logic [7:0]  ref_mem [N_BYTES];
  logic [31:0] last_rsp;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic int sz(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit f3_ok(input bit we, input logic [2:0] f3);
    if (we) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic bit crosses(input logic [31:0] addr, input logic [2:0] f3);
    return (int'(addr % 4) + sz(f3)) > 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    longint v;
    int     n;
    v = 0;
    n = sz(f3);
    for (int i = 0; i < n; i++)
      v = v + (longint'(ref_mem[(addr + i) % N_BYTES]) << (8 * i));
    if (f3[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    for (int i = 0; i < sz(f3); i++)
      ref_mem[(addr + i) % N_BYTES] = wd[8*i +: 8];
  endtask

  // Per-cycle snapshot of the memory-side outputs during the last request.
  logic [MEM_AW-1:0] rec_addr [4];
  logic [3:0]        rec_be   [4];
  logic [31:0]       rec_wd   [4];
  logic              rec_we   [4];
  logic              rec_rdy  [4];

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int cycles);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_funct3_i = f3;
    bus.req_addr_i   = addr;
    bus.req_wdata_i  = wd;
    cycles = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      rec_addr[k] = bus.mem_addr_o;
      rec_be[k]   = bus.mem_be_o;
      rec_wd[k]   = bus.mem_wdata_o;
      rec_we[k]   = bus.mem_we_o;
      rec_rdy[k]  = bus.req_ready_o;
      cycles++;
      @(posedge clk_i);
      if (rec_rdy[k]) break;
      @(negedge clk_i);
    end
    @(negedge clk_i);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wd);
    bit          legal;
    int          exp_cyc;
    int          cyc;
    logic [31:0] exp_data;
    legal    = f3_ok(we, f3);
    exp_cyc  = (legal && crosses(addr, f3)) ? 2 : 1;
    exp_data = legal ? ref_load(f3, addr) : 32'd0;
    do_req(we, f3, addr, wd, cyc);
    #1;
    check_eq("cycles", cyc, exp_cyc);
    check_eq("err", {31'd0, bus.err_o}, {31'd0, !legal});
    check_eq("rsp_valid", {31'd0, bus.rsp_valid_o}, {31'd0, !we});
    if (!we) last_rsp = exp_data;
    check_eq(we ? "rsp_hold" : "rsp_data", bus.rsp_data_o, last_rsp);
    if (we && legal) ref_store(f3, addr, wd);
    @(negedge clk_i);
    #1;
    check_eq("pulse_end", {30'd0, bus.rsp_valid_o, bus.err_o}, 32'd0);
    @(negedge clk_i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [2:0]  f3;
    logic [31:0] a;
    bit          we;

    for (int i = 0; i < N_WORDS; i++) begin
      w      = $urandom;
      mem[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end
    last_rsp = 32'd0;

    bus_nm.req_valid_i  = 1'b0;
    bus_nm.req_we_i     = 1'b0;
    bus_nm.req_funct3_i = 3'd0;
    bus_nm.req_addr_i   = 32'd0;
    bus_nm.req_wdata_i  = 32'd0;

    // A store presented during reset must not reach memory.
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b1;
    bus.req_funct3_i = 3'd2;
    bus.req_addr_i   = 32'd0;
    bus.req_wdata_i  = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk_i);
    #1;
    check_eq("rst_we", {31'd0, bus.mem_we_o}, 32'd0);
    check_eq("rst_be", {28'd0, bus.mem_be_o}, 32'd0);
    check_eq("rst_rsp", {30'd0, bus.rsp_valid_o, bus.err_o}, 32'd0);
    check_eq("rst_data", bus.rsp_data_o, 32'd0);
    @(negedge clk_i);
    bus.req_valid_i = 1'b0;
    rstn_i = 1'b1;
    @(negedge clk_i);

    // Aligned word store.
    op(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    check_eq("sw_addr", 32'(rec_addr[0]), 32'd4);
    check_eq("sw_be", {28'd0, rec_be[0]}, 32'hF);
    check_eq("sw_wd", rec_wd[0], 32'hDEAD_BEEF);
    check_eq("sw_rdy", {31'd0, rec_rdy[0]}, 32'd1);

    // Byte store into the top lane, then signed/unsigned byte loads.
    op(1'b1, 3'd0, 32'h13, 32'h0000_00A5);
    check_eq("sb_be", {28'd0, rec_be[0]}, 32'h8);
    check_eq("sb_wd", rec_wd[0], 32'hA500_0000);
    op(1'b0, 3'd0, 32'h13, 32'd0);
    check_eq("lb_val", bus.rsp_data_o, 32'hFFFF_FFA5);
    op(1'b0, 3'd4, 32'h13, 32'd0);
    check_eq("lbu_val", bus.rsp_data_o, 32'h0000_00A5);

    // Halfword from the upper lane pair.
    op(1'b1, 3'd2, 32'h10, 32'h8001_0000);
    op(1'b0, 3'd1, 32'h12, 32'd0);
    check_eq("lh_val", bus.rsp_data_o, 32'hFFFF_8001);
    op(1'b0, 3'd5, 32'h12, 32'd0);
    check_eq("lhu_val", bus.rsp_data_o, 32'h0000_8001);

    // Word store crossing a word boundary.
    op(1'b1, 3'd2, 32'h0D, 32'h1122_3344);
    check_eq("split_a0", 32'(rec_addr[0]), 32'd3);
    check_eq("split_be0", {28'd0, rec_be[0]}, 32'hE);
    check_eq("split_wd0", rec_wd[0], 32'h2233_4400);
    check_eq("split_rdy0", {31'd0, rec_rdy[0]}, 32'd0);
    check_eq("split_a1", 32'(rec_addr[1]), 32'd4);
    check_eq("split_be1", {28'd0, rec_be[1]}, 32'h1);
    check_eq("split_wd1", rec_wd[1], 32'h0000_0011);
    check_eq("split_rdy1", {31'd0, rec_rdy[1]}, 32'd1);
    op(1'b0, 3'd2, 32'h0D, 32'd0);
    check_eq("lw_split", bus.rsp_data_o, 32'h1122_3344);

    // Halfword at the last byte wraps to word 0.
    op(1'b1, 3'd1, 32'h1FFF, 32'h0000_BEEF);
    check_eq("wrap_a1", 32'(rec_addr[1]), 32'd0);
    check_eq("wrap_be1", {28'd0, rec_be[1]}, 32'h1);
    op(1'b0, 3'd1, 32'h1FFF, 32'd0);
    check_eq("wrap_lh", bus.rsp_data_o, 32'hFFFF_BEEF);

    // Illegal encodings.
    op(1'b1, 3'd3, 32'h20, 32'hCAFE_F00D);
    check_eq("ill_st_we", {31'd0, rec_we[0]}, 32'd0);
    op(1'b1, 3'd4, 32'h20, 32'hCAFE_F00D);
    op(1'b0, 3'd7, 32'h20, 32'd0);

    // Reset while the second half of a split store is pending.
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b1;
    bus.req_funct3_i = 3'd2;
    bus.req_addr_i   = 32'h2D;
    bus.req_wdata_i  = 32'hA1B2_C3D4;
    @(posedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b0;
    #1;
    check_eq("midrst_we", {31'd0, bus.mem_we_o}, 32'd0);
    check_eq("midrst_be", {28'd0, bus.mem_be_o}, 32'd0);
    check_eq("midrst_rsp", {30'd0, bus.rsp_valid_o, bus.err_o}, 32'd0);
    check_eq("midrst_data", bus.rsp_data_o, 32'd0);
    bus.req_valid_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    for (int i = 0; i < 3; i++) ref_mem[32'h2D + i] = 8'(32'hA1B2_C3D4 >> (8 * i));
    last_rsp = 32'd0;
    op(1'b0, 3'd2, 32'h2C, 32'd0);
    op(1'b0, 3'd2, 32'h30, 32'd0);

    // MISALIGN_EN=0 instance: aligned load works, crossing accesses rejected.
    bus_nm.req_valid_i  = 1'b1;
    bus_nm.req_we_i     = 1'b0;
    bus_nm.req_funct3_i = 3'd2;
    bus_nm.req_addr_i   = 32'h0;
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check_eq("nm_lw_ok", bus_nm.rsp_data_o, 32'h1234_5678);
    bus_nm.req_addr_i = 32'h2;
    #1;
    check_eq("nm_rdy", {31'd0, bus_nm.req_ready_o}, 32'd1);
    check_eq("nm_be", {28'd0, bus_nm.mem_be_o}, 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    bus_nm.req_we_i   = 1'b1;
    bus_nm.req_addr_i = 32'h3;
    #1;
    check_eq("nm_err", {31'd0, bus_nm.err_o}, 32'd1);
    check_eq("nm_rsp_v", {31'd0, bus_nm.rsp_valid_o}, 32'd1);
    check_eq("nm_rsp_d", bus_nm.rsp_data_o, 32'd0);
    check_eq("nm_st_we", {31'd0, bus_nm.mem_we_o}, 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    bus_nm.req_valid_i = 1'b0;
    #1;
    check_eq("nm_st_err", {31'd0, bus_nm.err_o}, 32'd1);
    check_eq("nm_st_rsp", {31'd0, bus_nm.rsp_valid_o}, 32'd0);
    @(negedge clk_i);

    // Random mix of loads and stores over a small window plus the top of memory.
    for (int n = 0; n < 300; n++) begin
      we = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we)                   f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end
      if ($urandom_range(0, 4) == 0) a = 32'($urandom_range(N_BYTES - 8, N_BYTES - 1));
      else                           a = 32'($urandom_range(0, 47));
      a = a | (32'($urandom_range(0, 3)) << 13);
      op(we, f3, a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
